// File: rtl/dwc_pkg.sv
// Shared widths, output range and int8 saturation helper for the depthwise-conv
// requantization stage.
package dwc_pkg;

    localparam int LANES   = 4;
    localparam int SUM_W   = 32;
    localparam int MULT_W  = 16;
    localparam int SHIFT_W = 5;
    localparam int OUT_W   = 8;
    localparam int QMIN    = -128;
    localparam int QMAX    = 127;

    // Growth through the datapath: bias add, multiply, rounding add, zero-point add.
    localparam int T_W    = SUM_W + 1;
    localparam int PROD_W = T_W + MULT_W;
    localparam int RND_W  = PROD_W + 1;
    localparam int Q_W    = RND_W + 1;

    function automatic logic signed [OUT_W-1:0] sat8(
        input logic signed [Q_W-1:0]   x,
        input logic signed [OUT_W-1:0] lo
    );
        logic signed [Q_W-1:0] lo_x;
        logic signed [Q_W-1:0] hi_x;
        lo_x = Q_W'(lo);
        hi_x = Q_W'(QMAX);
        if (x < lo_x) return lo;
        if (x > hi_x) return OUT_W'(QMAX);
        return x[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/dwc_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; a push that would overflow
// is ignored unless a pop frees the slot in the same cycle.
module dwc_sync_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/dwc_requant_stage.sv
// Requantizes four int32 row sums per beat to packed int8 behind a credit-based input and FIFO.
// Optional build macro DWC_RQ_RELU_EN clamps the low end of each output at the zero point.
module dwc_requant_stage
    import dwc_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [SUM_W-1:0]       in_sum0,
    input  logic [SUM_W-1:0]       in_sum1,
    input  logic [SUM_W-1:0]       in_sum2,
    input  logic [SUM_W-1:0]       in_sum3,
    output logic                   in_ready,
    input  logic                   cfg_load,
    input  logic [SUM_W-1:0]       cfg_bias,
    input  logic [MULT_W-1:0]      cfg_mult,
    input  logic [SHIFT_W-1:0]     cfg_shift,
    input  logic [OUT_W-1:0]       cfg_zp,
    output logic [LANES*OUT_W-1:0] m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   idle,
    output logic                   err_ovf,
    output logic                   err_cfg,
    input  logic                   err_clr
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic signed [SUM_W-1:0]   bias_q;
    logic signed [MULT_W-1:0]  mult_q;
    logic        [SHIFT_W-1:0] shift_q;
    logic signed [OUT_W-1:0]   zp_q;
    logic                      err_ovf_q, err_ovf_d;
    logic                      err_cfg_q, err_cfg_d;

    logic                      vld_p0_q, vld_p1_q, vld_p2_q;
    logic signed [T_W-1:0]     t_p0_q [LANES];
    logic signed [PROD_W-1:0]  p_p1_q [LANES];
    logic [LANES*OUT_W-1:0]    data_p2_q;

    logic signed [SUM_W-1:0]   sum_in [LANES];
    logic [1:0]                inflight;
    logic [CNT_W-1:0]          fifo_count;
    logic [LANES*OUT_W-1:0]    fifo_rdata;
    logic                      fifo_empty;
    logic                      fifo_pop;
    logic                      accept;
    logic                      cfg_ok;

    function automatic logic signed [RND_W-1:0] round_shift(
        input logic signed [PROD_W-1:0] p,
        input logic [SHIFT_W-1:0]       sh
    );
        logic signed [RND_W-1:0] pe;
        logic signed [RND_W-1:0] half;
        pe = RND_W'(p);
        if (sh == '0) return pe;
        half = RND_W'(1) << (sh - SHIFT_W'(1));
        return (pe + half) >>> sh;
    endfunction

    function automatic logic [OUT_W-1:0] requant(
        input logic signed [PROD_W-1:0] p,
        input logic [SHIFT_W-1:0]       sh,
        input logic signed [OUT_W-1:0]  zp
    );
        logic signed [Q_W-1:0]   q;
        logic signed [OUT_W-1:0] lo;
        q = Q_W'(round_shift(p, sh)) + Q_W'(zp);
`ifdef DWC_RQ_RELU_EN
        // An int8 zero point can never sit below QMIN, so max(zp, QMIN) is zp.
        lo = zp;
`else
        lo = OUT_W'(QMIN);
`endif
        return sat8(q, lo);
    endfunction

    assign sum_in[0] = in_sum0;
    assign sum_in[1] = in_sum1;
    assign sum_in[2] = in_sum2;
    assign sum_in[3] = in_sum3;

    // Credit counts beats already in flight so a full pipe can always land in the FIFO.
    assign inflight = 2'(vld_p0_q) + 2'(vld_p1_q) + 2'(vld_p2_q);
    assign in_ready = (fifo_count + CNT_W'(inflight)) < CNT_W'(DEPTH);
    assign accept   = in_valid && in_ready;
    assign idle     = !vld_p0_q && !vld_p1_q && !vld_p2_q && fifo_empty;
    assign cfg_ok   = cfg_load && idle && !in_valid;

    always_comb begin
        err_ovf_d = err_ovf_q || (in_valid && !in_ready);
        err_cfg_d = err_cfg_q || (cfg_load && !cfg_ok);
        if (err_clr) begin
            err_ovf_d = 1'b0;
            err_cfg_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0_q  <= 1'b0;
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            bias_q    <= '0;
            mult_q    <= MULT_W'(1);
            shift_q   <= '0;
            zp_q      <= '0;
            err_ovf_q <= 1'b0;
            err_cfg_q <= 1'b0;
        end else begin
            vld_p0_q  <= accept;
            vld_p1_q  <= vld_p0_q;
            vld_p2_q  <= vld_p1_q;
            err_ovf_q <= err_ovf_d;
            err_cfg_q <= err_cfg_d;
            if (cfg_ok) begin
                bias_q  <= cfg_bias;
                mult_q  <= cfg_mult;
                shift_q <= cfg_shift;
                zp_q    <= cfg_zp;
            end
        end
    end

    always_ff @(posedge clk) begin
        // p0: bias add at 33 bits
        if (accept) begin
            for (int l = 0; l < LANES; l++) begin
                t_p0_q[l] <= T_W'(sum_in[l]) + T_W'(bias_q);
            end
        end
        // p1: signed multiply
        if (vld_p0_q) begin
            for (int l = 0; l < LANES; l++) begin
                p_p1_q[l] <= PROD_W'(t_p0_q[l]) * PROD_W'(mult_q);
            end
        end
        // p2: rounding shift, zero point, saturate, pack
        if (vld_p1_q) begin
            for (int l = 0; l < LANES; l++) begin
                data_p2_q[l*OUT_W +: OUT_W] <= requant(p_p1_q[l], shift_q, zp_q);
            end
        end
    end

    dwc_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (LANES*OUT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (vld_p2_q),
        .wdata_i (data_p2_q),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    assign m_valid  = !fifo_empty;
    assign fifo_pop = m_valid && m_ready;
    assign m_data   = m_valid ? fifo_rdata : '0;
    assign err_ovf  = err_ovf_q;
    assign err_cfg  = err_cfg_q;

endmodule

// File: tb/tb_dwc_requant_stage.sv
// Directed bench for dwc_requant_stage: reset, arithmetic vectors, credit/overflow,
// config gating and mid-run reset.
module tb_dwc_requant_stage;

    localparam int DEPTH = 8;

`ifdef DWC_RQ_RELU_EN
    localparam logic [31:0] EXP_T2  = 32'h00010002;
    localparam logic [31:0] EXP_T3  = 32'h0F050505;
    localparam logic [31:0] EXP_MX  = 32'h007F0000;
    localparam logic [31:0] EXP_T6  = 32'h7F7F0001;
`else
    localparam logic [31:0] EXP_T2  = 32'h0001FF02;
    localparam logic [31:0] EXP_T3  = 32'h0F80FBFF;
    localparam logic [31:0] EXP_MX  = 32'h00FF7F80;
    localparam logic [31:0] EXP_T6  = 32'h7F7FFE01;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_sum0, in_sum1, in_sum2, in_sum3;
    logic        in_ready;
    logic        cfg_load;
    logic [31:0] cfg_bias;
    logic [15:0] cfg_mult;
    logic [4:0]  cfg_shift;
    logic [7:0]  cfg_zp;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        idle;
    logic        err_ovf;
    logic        err_cfg;
    logic        err_clr;

    int n_cmp;
    int n_err;
    int acc;

    dwc_requant_stage #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sum0   (in_sum0),
        .in_sum1   (in_sum1),
        .in_sum2   (in_sum2),
        .in_sum3   (in_sum3),
        .in_ready  (in_ready),
        .cfg_load  (cfg_load),
        .cfg_bias  (cfg_bias),
        .cfg_mult  (cfg_mult),
        .cfg_shift (cfg_shift),
        .cfg_zp    (cfg_zp),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .idle      (idle),
        .err_ovf   (err_ovf),
        .err_cfg   (err_cfg),
        .err_clr   (err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, required finish before timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int bias, input int mult, input int shift, input int zp);
        cfg_bias  = bias;
        cfg_mult  = 16'(mult);
        cfg_shift = 5'(shift);
        cfg_zp    = 8'(zp);
        cfg_load  = 1'b1;
        tick();
        cfg_load  = 1'b0;
    endtask

    task automatic send_beat(input int s0, input int s1, input int s2, input int s3);
        in_sum0  = s0;
        in_sum1  = s1;
        in_sum2  = s2;
        in_sum3  = s3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] exp);
        int n;
        n = 0;
        while (!m_valid && n < 10) begin
            tick();
            n++;
        end
        check1({tag, "_valid"}, m_valid, 1'b1);
        check({tag, "_data"}, m_data, exp);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sum0   = '0;
        in_sum1   = '0;
        in_sum2   = '0;
        in_sum3   = '0;
        cfg_load  = 1'b0;
        cfg_bias  = '0;
        cfg_mult  = '0;
        cfg_shift = '0;
        cfg_zp    = '0;
        m_ready   = 1'b0;
        err_clr   = 1'b0;
        tick();
        tick();
        check1("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, 32'h0);
        check1("rst_in_ready", in_ready, 1'b1);
        check1("rst_idle", idle, 1'b1);
        check1("rst_err_ovf", err_ovf, 1'b0);
        check1("rst_err_cfg", err_cfg, 1'b0);
        rst = 1'b0;
        tick();

        // T1: unity gain via mult/shift, latency of four cycles
        set_cfg(0, 16384, 14, 0);
        check1("t1_idle", idle, 1'b1);
        send_beat(100, -50, 3, 200);
        check1("t1_lat0", m_valid, 1'b0);
        check1("t1_busy", idle, 1'b0);
        tick();
        check1("t1_lat1", m_valid, 1'b0);
        tick();
        check1("t1_lat2", m_valid, 1'b0);
        tick();
        check1("t1_lat3", m_valid, 1'b1);
        check("t1_data", m_data, 32'h7F03CE64);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check1("t1_drained", m_valid, 1'b0);
        check1("t1_idle_after", idle, 1'b1);

        // T2: round half up on a shift of one
        set_cfg(0, 1, 1, 0);
        send_beat(3, -3, 1, -1);
        pop_expect("t2", EXP_T2);

        // T3: bias and zero point with low saturation
        set_cfg(-10, 1, 0, 5);
        send_beat(4, 0, -300, 20);
        pop_expect("t3", EXP_T3);

        // Extreme multiplier and maximum shift
        set_cfg(0, -32768, 31, 0);
        send_beat(32'h7FFFFFFF, 32'h80000000, 65536, 0);
        pop_expect("mult_extreme", EXP_MX);

        // Bias add must not wrap at 32 bits
        set_cfg(32'h7FFFFFFF, 1, 31, 0);
        send_beat(32'h7FFFFFFF, 32'h80000001, 0, 0);
        pop_expect("bias_33b", 32'h01010002);

        // T4: credit exhaustion with the consumer stalled
        set_cfg(0, 1, 0, 0);
        m_ready  = 1'b0;
        acc      = 0;
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_sum0 = acc + 1;
            in_sum1 = 0;
            in_sum2 = 0;
            in_sum3 = 0;
            if (!in_ready) break;
            tick();
            acc++;
        end
        check("t4_accepts", acc, DEPTH);
        check1("t4_ready_low", in_ready, 1'b0);
        check1("t4_ovf_not_yet", err_ovf, 1'b0);
        tick();
        in_valid = 1'b0;
        check1("t4_ovf_set", err_ovf, 1'b1);
        check("t4_head", m_data, 32'h1);
        tick();
        tick();
        check1("t4_ovf_sticky", err_ovf, 1'b1);
        check("t4_head_held", m_data, 32'h1);
        in_valid = 1'b1;
        err_clr  = 1'b1;
        tick();
        in_valid = 1'b0;
        err_clr  = 1'b0;
        check1("t4_clr_priority", err_ovf, 1'b0);
        m_ready = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            check1("t4_drain_valid", m_valid, 1'b1);
            check("t4_drain_data", m_data, 32'(i));
            tick();
        end
        m_ready = 1'b0;
        check1("t4_empty", m_valid, 1'b0);
        check1("t4_ready_back", in_ready, 1'b1);
        check1("t4_idle", idle, 1'b1);

        // T5: config load gated by idle
        send_beat(10, 0, 0, 0);
        cfg_bias = 5;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        check1("t5_err_cfg_busy", err_cfg, 1'b1);
        pop_expect("t5_old_cfg", 32'h0000000A);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check1("t5_err_cfg_clr", err_cfg, 1'b0);
        cfg_bias = 7;
        cfg_load = 1'b1;
        in_sum0  = 20;
        in_sum1  = 0;
        in_sum2  = 0;
        in_sum3  = 0;
        in_valid = 1'b1;
        tick();
        cfg_load = 1'b0;
        in_valid = 1'b0;
        check1("t5_err_cfg_same", err_cfg, 1'b1);
        pop_expect("t5_same_cycle", 32'h00000014);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        set_cfg(5, 1, 0, 0);
        check1("t5_err_cfg_idle", err_cfg, 1'b0);
        send_beat(10, 0, 0, 0);
        pop_expect("t5_new_cfg", 32'h0505050F);

        // T6: asynchronous reset with three entries queued
        set_cfg(0, 2, 0, 0);
        send_beat(1, 1, 1, 1);
        send_beat(1, 1, 1, 1);
        send_beat(1, 1, 1, 1);
        tick();
        tick();
        tick();
        tick();
        check1("t6_queued", m_valid, 1'b1);
        cfg_mult = 16'd3;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        check1("t6_err_cfg", err_cfg, 1'b1);
        rst = 1'b1;
        #1;
        check1("t6_m_valid", m_valid, 1'b0);
        check("t6_m_data", m_data, 32'h0);
        check1("t6_in_ready", in_ready, 1'b1);
        check1("t6_idle", idle, 1'b1);
        check1("t6_err_cfg_rst", err_cfg, 1'b0);
        tick();
        rst = 1'b0;
        send_beat(1, -2, 127, 300);
        pop_expect("t6_default_cfg", EXP_T6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
